// File: rtl/seg_display_scan_pkg.sv
// Shared constants for the six-digit HH:MM:SS scanner: digit indexing and
// active-high 7-segment patterns in {g,f,e,d,c,b,a} order.
package seg_display_scan_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;

    localparam digit_idx_t LAST_DIGIT  = 3'd5;
    localparam digit_idx_t COLON_IDX_A = 3'd2;
    localparam digit_idx_t COLON_IDX_B = 3'd4;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Active-high one-hot anode vector for a digit index; out-of-range gives none.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        logic [NUM_DIGITS-1:0] v;
        v = '0;
        case (idx)
            3'd0: v = 6'b000001;
            3'd1: v = 6'b000010;
            3'd2: v = 6'b000100;
            3'd3: v = 6'b001000;
            3'd4: v = 6'b010000;
            3'd5: v = 6'b100000;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/seg_display_scan_bcd_to_seg.sv
// Combinational BCD to active-high 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
    import seg_display_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Six-digit multiplexed 7-segment scanner with per-frame snapshot, anode guard
// time and even-second colon. Define SEG_BLINK_EN to add per-digit blinking.
module seg_display_scan
    import seg_display_scan_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int GUARD_CYC   = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [3:0]            i_hour_tens,
    input  logic [3:0]            i_hour_ones,
    input  logic [3:0]            i_min_tens,
    input  logic [3:0]            i_min_ones,
    input  logic [3:0]            i_sec_tens,
    input  logic [3:0]            i_sec_ones,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0] i_blink_mask,
`endif
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [NUM_DIGITS-1:0] o_an
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_VAL = CNT_W'(GUARD_CYC);
    localparam logic [6:0]            SEG_INV   = {7{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV    = {NUM_DIGITS{AN_ACT_LOW}};

    logic [CNT_W-1:0]           r_cnt;
    digit_idx_t                 r_idx;
    logic [NUM_DIGITS-1:0][3:0] r_snap;
    logic                       r_load_pend;
    logic [6:0]                 r_seg;
    logic                       r_dp;
    logic [NUM_DIGITS-1:0]      r_an;

    logic                  w_tick;
    logic                  w_guard;
    logic                  w_blank;
    logic [3:0]            w_digit;
    logic [6:0]            w_pattern;
    logic [6:0]            w_seg_act;
    logic                  w_dp_act;
    logic [NUM_DIGITS-1:0] w_an_act;

    assign w_tick  = (r_cnt == CNT_LAST);
    assign w_guard = (r_cnt < GUARD_VAL);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == LAST_DIGIT) ? digit_idx_t'(0) : r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The snapshot is only refreshed at frame boundaries so a carry rippling
    // through the counters upstream can never tear a displayed frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_snap      <= '0;
            r_load_pend <= 1'b1;
        end else if (r_load_pend || (w_tick && r_idx == LAST_DIGIT)) begin
            r_snap      <= {i_hour_tens, i_hour_ones, i_min_tens,
                            i_min_ones, i_sec_tens, i_sec_ones};
            r_load_pend <= 1'b0;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int HALF = CLK_HZ / 2;
    localparam int PH_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PH_W-1:0] PH_RELOAD = PH_W'(HALF - 1);

    logic [PH_W-1:0] r_phase_cnt;
    logic            r_phase;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase_cnt <= PH_RELOAD;
            r_phase     <= 1'b0;
        end else if (r_phase_cnt == '0) begin
            r_phase_cnt <= PH_RELOAD;
            r_phase     <= ~r_phase;
        end else begin
            r_phase_cnt <= r_phase_cnt - 1'b1;
        end
    end

    always_comb begin
        w_blank = 1'b0;
        if (r_phase) begin
            case (r_idx)
                3'd0: w_blank = i_blink_mask[0];
                3'd1: w_blank = i_blink_mask[1];
                3'd2: w_blank = i_blink_mask[2];
                3'd3: w_blank = i_blink_mask[3];
                3'd4: w_blank = i_blink_mask[4];
                3'd5: w_blank = i_blink_mask[5];
                default: w_blank = 1'b0;
            endcase
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0: w_digit = r_snap[0];
            3'd1: w_digit = r_snap[1];
            3'd2: w_digit = r_snap[2];
            3'd3: w_digit = r_snap[3];
            3'd4: w_digit = r_snap[4];
            3'd5: w_digit = r_snap[5];
            default: w_digit = 4'd0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .i_bcd (w_digit),
        .o_seg (w_pattern)
    );

    // Segments are blanked along with the anodes during guard so nothing of
    // the previous digit's pattern can ghost onto the next anode.
    always_comb begin
        w_an_act  = '0;
        w_seg_act = SEG_BLANK;
        w_dp_act  = 1'b0;
        if (!w_guard) begin
            w_an_act = digit_onehot(r_idx);
            if (!w_blank) begin
                w_seg_act = w_pattern;
                w_dp_act  = ((r_idx == COLON_IDX_A) || (r_idx == COLON_IDX_B))
                            && !r_snap[0][0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seg <= SEG_INV;
            r_dp  <= SEG_ACT_LOW;
            r_an  <= AN_INV;
        end else begin
            r_seg <= w_seg_act ^ SEG_INV;
            r_dp  <= w_dp_act ^ SEG_ACT_LOW;
            r_an  <= w_an_act ^ AN_INV;
        end
    end

    assign o_seg = r_seg;
    assign o_dp  = r_dp;
    assign o_an  = r_an;

endmodule
